// File: rtl/spi_motor_regfile.sv
// Header-addressed command decoder and per-motor register bank behind the SPI slave word port.
// Supports burst write/read with per-motor address wrap, optional atomic shadow commit, and error counting.
module spi_motor_regfile #(
    parameter int          NUMBER_OF_MOTORS = 4,
    parameter int          NUMBER_OF_REGS   = 8,
    parameter bit          SHADOWED         = 1'b1,
    parameter logic [31:0] RESET_VALUE      = 32'h0
) (
    input  logic                                       iCLK,
    input  logic                                       iRESET,
    input  logic                                       iCS_n,
    input  logic                                       iRX_VALID,
    input  logic [31:0]                                iRX_DATA,
    output logic [31:0]                                oTX_DATA,
    output logic                                       oTX_LOAD,
    output logic [NUMBER_OF_MOTORS*NUMBER_OF_REGS*32-1:0] oREG_FLAT,
    output logic [NUMBER_OF_MOTORS-1:0]                oUPDATE,
    output logic                                       oBUSY,
    output logic [7:0]                                 oERR_CNT
);
    localparam int NR = NUMBER_OF_MOTORS * NUMBER_OF_REGS;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_SKIP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_active [NR];
    logic [31:0] r_shadow [NR];
    logic [7:0]  r_motor;
    logic [7:0]  r_addr;
    logic [7:0]  r_cnt;

    logic        w_abort, w_hdr, w_word, w_hdr_bad, w_hdr_ok, w_h_wr, w_last;
    logic [7:0]  w_h_motor, w_h_start, w_h_cnt, w_addr_inc;
    int          w_cur_idx, w_next_idx, w_hdr_idx;
    logic [31:0] w_rd_hdr, w_rd_next;

    assign w_h_wr    = iRX_DATA[31];
    assign w_h_motor = iRX_DATA[23:16];
    assign w_h_start = iRX_DATA[15:8];
    assign w_h_cnt   = iRX_DATA[7:0];

    // A frame-select deassertion outranks any word arriving in the same cycle
    assign w_abort   = iCS_n && (r_state != S_IDLE);
    assign w_hdr     = (r_state == S_IDLE) && !iCS_n && iRX_VALID;
    assign w_word    = (r_state != S_IDLE) && !iCS_n && iRX_VALID;
    assign w_hdr_bad = w_hdr && ((int'(w_h_motor) >= NUMBER_OF_MOTORS) ||
                                 (int'(w_h_start) >= NUMBER_OF_REGS));
    assign w_hdr_ok  = w_hdr && !w_hdr_bad && (w_h_cnt != 8'd0);
    assign w_last    = (r_cnt == 8'd1);

    assign w_addr_inc = (int'(r_addr) == NUMBER_OF_REGS - 1) ? 8'd0 : r_addr + 8'd1;
    assign w_cur_idx  = int'(r_motor) * NUMBER_OF_REGS + int'(r_addr);
    assign w_next_idx = int'(r_motor) * NUMBER_OF_REGS + int'(w_addr_inc);
    assign w_hdr_idx  = int'(w_h_motor) * NUMBER_OF_REGS + int'(w_h_start);

    always_comb begin
        w_rd_hdr  = '0;
        w_rd_next = '0;
        for (int i = 0; i < NR; i++) begin
            if (i == w_hdr_idx)  w_rd_hdr  = r_active[i];
            if (i == w_next_idx) w_rd_next = r_active[i];
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_flat
        assign oREG_FLAT[g*32 +: 32] = r_active[g];
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hdr_bad && (w_h_cnt != 8'd0)) w_next = S_SKIP;
                    else if (w_hdr_ok)                  w_next = w_h_wr ? S_WRITE : S_READ;
                end
                default: begin
                    if (w_word && w_last) w_next = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        oBUSY = (r_state != S_IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int i = 0; i < NR; i++) begin
                r_active[i] <= RESET_VALUE;
                r_shadow[i] <= RESET_VALUE;
            end
            oTX_DATA <= '0;
            oTX_LOAD <= 1'b0;
            oUPDATE  <= '0;
            oERR_CNT <= '0;
            r_motor  <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
        end else begin
            oTX_LOAD <= 1'b0;
            oUPDATE  <= '0;
            if ((w_abort || w_hdr_bad) && (oERR_CNT != 8'hFF))
                oERR_CNT <= oERR_CNT + 8'd1;

            if (w_hdr) begin
                r_motor <= w_h_motor;
                r_addr  <= w_h_start;
                r_cnt   <= w_h_cnt;
            end
            // Shadow starts as a snapshot so a partial burst commits untouched regs unchanged
            if (SHADOWED && w_hdr_ok && w_h_wr) begin
                for (int i = 0; i < NR; i++)
                    if (i / NUMBER_OF_REGS == int'(w_h_motor)) r_shadow[i] <= r_active[i];
            end
            if (w_hdr_ok && !w_h_wr) begin
                oTX_DATA <= w_rd_hdr;
                oTX_LOAD <= 1'b1;
            end

            if (w_word) begin
                r_addr <= w_addr_inc;
                r_cnt  <= r_cnt - 8'd1;
                if (r_state == S_WRITE) begin
                    for (int i = 0; i < NR; i++) begin
                        if (SHADOWED) begin
                            if (i == w_cur_idx) r_shadow[i] <= iRX_DATA;
                            if (w_last && (i / NUMBER_OF_REGS == int'(r_motor)))
                                r_active[i] <= (i == w_cur_idx) ? iRX_DATA : r_shadow[i];
                        end else if (i == w_cur_idx) begin
                            r_active[i] <= iRX_DATA;
                        end
                    end
                    if (w_last) begin
                        for (int m = 0; m < NUMBER_OF_MOTORS; m++)
                            if (m == int'(r_motor)) oUPDATE[m] <= 1'b1;
                    end
                end else if ((r_state == S_READ) && !w_last) begin
                    oTX_DATA <= w_rd_next;
                    oTX_LOAD <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/spi_motor_regfile.md
Name: spi_motor_regfile

Overview:
- Parametrised command decoder and register bank that sits behind the SPI slave word interface.
- Replaces ad-hoc Kp/Ki decode with a framed, header-addressed protocol.
- Supports N motors x M 32-bit registers, burst write/read with address auto-increment, optional shadowed (atomic) commit, and error counting.
- Outputs feed per-motor PID/control blocks; readback words feed the SPI slave transmit input.

Parameters:
- NUMBER_OF_MOTORS, 4, motor banks (1..256)
- NUMBER_OF_REGS, 8, 32-bit registers per motor (1..256)
- SHADOWED, 1, 1 = burst writes go to a shadow bank and commit atomically at burst end; 0 = direct write
- RESET_VALUE, 32'h0, reset/initial value of every register

Ports:
- iCLK  in  1  system clock
- iRESET  in  1  synchronous, active-high reset
- iCS_n  in  1  SPI frame select, high = no frame; a rising edge aborts any burst
- iRX_VALID  in  1  one-cycle pulse, received word valid
- iRX_DATA  in  32  received word
- oTX_DATA  out  32  word for the SPI slave to shift out on the next transfer
- oTX_LOAD  out  1  one-cycle pulse, oTX_DATA updated
- oREG_FLAT  out  NUMBER_OF_MOTORS*NUMBER_OF_REGS*32  active registers; motor m, reg r at bits [(m*NUMBER_OF_REGS+r)*32 +: 32]
- oUPDATE  out  NUMBER_OF_MOTORS  one-cycle pulse per motor whose active registers changed
- oBUSY  out  1  high while not in IDLE
- oERR_CNT  out  8  saturating count of rejected headers and aborted bursts

Behaviour:
- Reset:
  - all registers (active and shadow) = RESET_VALUE
  - oTX_DATA = 0; oTX_LOAD = 0; oUPDATE = 0; oBUSY = 0; oERR_CNT = 0
  - state = IDLE
  - reset mid-burst discards everything; no commit, no oUPDATE
- Header word (first iRX_VALID while in IDLE and iCS_n low):
  - [31] = W (1 write, 0 read); [30:24] ignored; [23:16] motor index; [15:8] start register; [7:0] count N
- States: IDLE, WRITE, READ, SKIP.
- IDLE:
  - Header with motor >= NUMBER_OF_MOTORS or start >= NUMBER_OF_REGS: oERR_CNT increments (saturating at 255); if N > 0 go to SKIP, else stay in IDLE.
  - Valid header with N = 0: no action, stay in IDLE.
  - Valid write header: go to WRITE. If SHADOWED, the selected motor's shadow bank is loaded from its active bank in the same cycle.
  - Valid read header: go to READ; oTX_DATA = reg[start] and oTX_LOAD pulses 1 cycle after the header.
- WRITE: each iRX_VALID writes the data word to reg[addr], then addr increments and N decrements.
  - addr wraps from NUMBER_OF_REGS-1 to 0 within the same motor.
  - When N reaches 0, return to IDLE.
  - SHADOWED = 1: shadow is copied to active on the cycle after the last word; oUPDATE[m] pulses in that same cycle.
  - SHADOWED = 0: each word writes active directly; oUPDATE[m] pulses once, the cycle after the last word.
- READ: each iRX_VALID (dummy word, contents ignored) increments addr with the same wrap and decrements N.
  - While N > 0 after the decrement: load oTX_DATA = reg[addr] and pulse oTX_LOAD 1 cycle later.
  - When N reaches 0, return to IDLE with no further load.
  - Read latency is 1 cycle from iRX_VALID to oTX_LOAD.
- SKIP: consumes N words with no effect, then returns to IDLE.
- Abort: iCS_n high while not in IDLE:
  - return to IDLE the next cycle
  - oERR_CNT increments (saturating)
  - no commit and no oUPDATE; in direct mode, words already written stay written
- iRX_VALID in the same cycle as iCS_n high: the word is discarded; abort takes priority.
- iCS_n high while in IDLE: no effect.
- Read of a register in the same cycle as its commit returns the post-commit value.
- oBUSY = (state != IDLE).

Test Plan:
- Reset, then write header 0x8001_0002 + data 0x11, 0x22 (motor 1, regs 0..1) with SHADOWED=1 -> oREG_FLAT motor1 reg0 = 0x11, reg1 = 0x22, both appearing in the same cycle; oUPDATE = 4'b0010 for one cycle.
- Read header 0x0001_0002, then 2 dummy words -> oTX_LOAD pulses twice: first with 0x11 (1 cycle after header), then 0x22 (1 cycle after first dummy); oBUSY low after the second dummy.
- Wrap: NUMBER_OF_REGS=8, write header 0x8000_0703 + 0xA, 0xB, 0xC -> motor0 reg7 = 0xA, reg0 = 0xB, reg1 = 0xC.
- Invalid: header 0x8009_0002 (motor 9 >= 4) + 2 words -> oERR_CNT = 1; oREG_FLAT unchanged; no oUPDATE; oBUSY low after the 2nd word.
- Abort: write header 0x8002_0003 + one word 0x55, then iCS_n high -> SHADOWED=1: motor2 unchanged, no oUPDATE, oERR_CNT +1; SHADOWED=0: reg0 = 0x55, no oUPDATE.
- Error saturation: 300 invalid N=0 headers -> oERR_CNT = 255; then iRESET high for 1 cycle -> oERR_CNT = 0 and all registers = RESET_VALUE.
